// File: rtl/pid_plant_model.sv
// pid_plant_model
//   Discrete first-order plant emulator with transport delay. It closes the
//   PID loop on-chip: it takes the controller's actuator command and returns
//   the feedback byte that the controller reads.
//
//   Parameters
//     DIV    sample period in clk cycles (1..65535)
//     SHIFT  time-constant shift; per-sample gain is 2^-SHIFT (0..7)
//     DELAY  transport delay in samples (0..15); 0 removes the delay line
//
//   Ports
//     clk             clock; all state updates on the rising edge
//     rst_n           asynchronous active-low reset
//     en              run enable; when low, the divider and plant state hold
//     control_signal  unsigned actuator command u
//     disturbance     signed additive output load d, sampled at ticks only
//     feedback        registered plant output, clamped to 0..255
//     sample_tick     registered pulse, high in the cycle after each update
module pid_plant_model #(
    parameter int unsigned DIV   = 16,
    parameter int unsigned SHIFT = 2,
    parameter int unsigned DELAY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] control_signal,
    input  logic [7:0] disturbance,
    output logic [7:0] feedback,
    output logic       sample_tick
);

    localparam logic [15:0] CNT_MAX = 16'(DIV - 1);

    logic [15:0]       cnt;
    logic              tick;
    logic [7:0]        y;
    logic [7:0]        u_d;
    logic [7:0]        y_new;
    logic [7:0]        fb_next;
    logic signed [8:0] diff;
    logic signed [8:0] step;
    logic signed [9:0] sum;

    assign tick = en && (cnt == CNT_MAX);

    // Sample-rate divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 16'd1;
        end
    end

    // Transport delay: the entry at ptr is the oldest command; it is read and
    // overwritten with the newest one on the same tick.
    generate
        if (DELAY == 0) begin : g_nodelay
            assign u_d = control_signal;
        end else begin : g_delay
            localparam int unsigned   PW      = (DELAY > 1) ? $clog2(DELAY) : 1;
            localparam logic [PW-1:0] PTR_MAX = PW'(DELAY - 1);

            logic [7:0]    dly_buf [DELAY];
            logic [PW-1:0] ptr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr <= '0;
                    for (int unsigned i = 0; i < DELAY; i++) begin
                        dly_buf[i] <= '0;
                    end
                end else if (tick) begin
                    dly_buf[ptr] <= control_signal;
                    ptr          <= (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
                end
            end

            assign u_d = dly_buf[ptr];
        end
    endgenerate

    // Plant update. Since |step| <= |diff| the new y stays in 0..255, so the
    // 8-bit truncation of y + step is exact. The forced step of 1 lets upward
    // moves finish; downward moves finish on their own because >>> floors.
    always_comb begin
        diff = $signed({1'b0, u_d}) - $signed({1'b0, y});
        step = diff >>> SHIFT;
        if (diff > 0 && step == 0) begin
            step = 9'sd1;
        end
        y_new = 8'($signed({1'b0, y}) + step);

        sum = $signed({2'b00, y_new}) + $signed({{2{disturbance[7]}}, disturbance});
        if (sum < 0) begin
            fb_next = '0;
        end else if (sum > 10'sd255) begin
            fb_next = '1;
        end else begin
            fb_next = sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y           <= '0;
            feedback    <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= tick;
            if (tick) begin
                y        <= y_new;
                feedback <= fb_next;
            end
        end
    end

endmodule

// File: doc/pid_plant_model.md
# pid_plant_model

Discrete first-order plant emulator with transport delay. It sits on the far end of the PID loop: it consumes the controller's 8-bit `control_signal` as actuator command and produces the 8-bit `feedback` byte the controller reads back. This closes the loop on-chip for bring-up and self-test without an external plant. Sample rate, time constant and dead time are set by parameters; a signed disturbance input lets the bench inject load steps.

## Interface
- `DIV`, 16, sample period in clk cycles; legal range 1..65535.
- `SHIFT`, 2, time-constant shift; per-sample gain is 2^-SHIFT; legal range 0..7.
- `DELAY`, 4, transport delay in samples; legal range 0..15; 0 means no delay line.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; when low, the divider and all plant state hold.
- `control_signal`  in  8  unsigned actuator command u.
- `disturbance`  in  8  signed (two's complement) additive output load d.
- `feedback`  out  8  registered, unsigned plant output.
- `sample_tick`  out  1  registered one-cycle pulse, high in the cycle after each update.

## Operation
- Divider `cnt` counts 0..DIV-1 while `en`=1 and wraps to 0.
- Tick condition: `en`=1 and `cnt`==DIV-1.
- No other state changes occur between ticks.
- Delay line: circular buffer of DELAY 8-bit entries plus write pointer `ptr` (0..DELAY-1, wraps DELAY-1 -> 0).
- On a tick:
  - If DELAY=0, u_d = `control_signal`.
  - Otherwise u_d = buf[ptr]; in the same cycle buf[ptr] <= `control_signal` and ptr advances.
  - Result: u sampled at tick k is used at tick k+DELAY.
- Plant state y is 8-bit unsigned, updated on each tick:
  - diff = {0,u_d} - {0,y}, 9-bit signed.
  - step = diff >>> SHIFT (arithmetic shift, floor).
  - If diff>0 and step==0, force step=1.
  - y <= y + step.
  - Because |step| <= |diff|, y stays within 0..255 and converges exactly to u_d in both directions. No clamping of y is needed.
- Output:
  - sum = y_new + sign-extended `disturbance`, evaluated at 10 bits signed.
  - `feedback` <= sum clamped to 0..255.
  - `disturbance` is sampled only at ticks.
- `sample_tick` <= 1 on the tick edge and 0 on every other edge.

## Timing
- Reset (async, immediate, mid-operation included) clears:
  - `feedback`=0, `sample_tick`=0
  - y=0, `cnt`=0, `ptr`=0
  - all buffer entries = 0
- After reset release with `en`=1, the first tick edge is the DIV-th rising edge. `feedback` changes on that edge and `sample_tick` is high for the following cycle.
- Ticks then recur every DIV enabled cycles.
- DIV=1: a tick occurs on every enabled edge and `sample_tick` stays high continuously.
- `en` low on a would-be tick cycle: no tick, `cnt` holds at DIV-1, and the tick occurs on the first edge with `en`=1.
- Command-to-output latency: a change in `control_signal` sampled at tick k first moves `feedback` on tick k+DELAY, which is the DELAY+1-th tick counting tick k as the first when DELAY=0.
- Simultaneous `en` deassert and reset assertion: reset wins.

## Test plan
- Reset mid-run: pulse `rst_n` low between ticks -> `feedback`=0 and `sample_tick`=0 without waiting for a clock edge. After release, the first `sample_tick` rises exactly 16 edges later (DIV=16).
- Step up (DIV=16, SHIFT=2, DELAY=4, u=200, d=0 from reset):
  - `feedback`=0 for ticks 1-4.
  - Tick 5 -> 50, tick 6 -> 87, tick 7 -> 115.
  - Eventually exactly 200 and holding.
- Step down (DELAY=0, SHIFT=2, y settled at 200, u=0) -> 150, 112, 84, ..., then 1 -> 0 and holds at 0.
- Disturbance clamp:
  - y=250, d=+20 -> `feedback`=255.
  - y=5, d=8'hEC (-20) -> `feedback`=0.
  - d=0 -> `feedback`=y.
- Enable gating (DIV=16): drop `en` for 10 cycles mid-period -> no tick during the gap, and the next tick arrives 10 cycles late. A gap straddling `cnt`=DIV-1 produces the tick on the first re-enabled edge.
- Passthrough (DIV=1, SHIFT=0, DELAY=0, d=0): `feedback` equals `control_signal` with one-cycle latency for a random sequence of 100 bytes, with `sample_tick` constantly high.
